// File: rtl/tbu_ctrl_if.sv
// ---------------------------------------------------------------------------
// tbu_ctrl_if
//   Bundle of the survivor-input and decoded-bit-output signals of the
//   Viterbi trace-back controller.
//   Signals:
//     di_sur_path    [63:0] survivor decision vector, bit i belongs to state i
//     di_sur_valid          di_sur_path valid this cycle
//     di_sur_last           final trellis step of the frame (with valid)
//     di_start_state [5:0]  trace-back start state, sampled with the last vector
//     do_bit                decoded bit
//     do_bit_valid          do_bit valid
//     do_bit_last           last decoded bit of the frame
//     do_busy               tracing or outputting, input not accepted
//     do_overflow           one-cycle pulse per dropped input vector
//   Modports: master = survivor source / bit sink, slave = the controller.
// ---------------------------------------------------------------------------
interface tbu_ctrl_if;
    logic [63:0] di_sur_path;
    logic        di_sur_valid;
    logic        di_sur_last;
    logic [5:0]  di_start_state;
    logic        do_bit;
    logic        do_bit_valid;
    logic        do_bit_last;
    logic        do_busy;
    logic        do_overflow;

    modport master (
        output di_sur_path, di_sur_valid, di_sur_last, di_start_state,
        input  do_bit, do_bit_valid, do_bit_last, do_busy, do_overflow
    );

    modport slave (
        input  di_sur_path, di_sur_valid, di_sur_last, di_start_state,
        output do_bit, do_bit_valid, do_bit_last, do_busy, do_overflow
    );
endinterface

// File: rtl/tbu_ctrl.sv
// ---------------------------------------------------------------------------
// tbu_ctrl
//   Frame-based trace-back controller for the K=7 (64-state) Viterbi decoder.
//   Survivor vectors are buffered one per trellis step; at frame end the
//   trellis is walked backwards from the supplied start state, one step per
//   cycle, and the decoded bits are then replayed in forward time order.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  tbu_ctrl_if.slave (survivor input, decoded bit output, status)
// ---------------------------------------------------------------------------
module tbu_ctrl #(
    parameter int MAX_LEN = 512,
    parameter int ADDR_W  = 9
) (
    input  logic       clk,
    input  logic       rst,
    tbu_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FILL, TRACE, OUTPUT} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] wr_cnt;     // next write address while accepting
    logic [ADDR_W-1:0] len_m1;     // frame length minus one (N-1)
    logic [ADDR_W-1:0] t_cnt;      // trellis step being traced
    logic [ADDR_W-1:0] out_cnt;    // index of the bit being emitted
    logic [5:0]        tb_state;   // S_{t+1} during TRACE
    logic              overflow_q;

    logic [63:0]        sur_ram [MAX_LEN];
    logic [63:0]        rd_data;
    logic [MAX_LEN-1:0] bit_buf;

    logic              wr_en;
    logic              frame_end;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    assign wr_en     = (state_q == IDLE) && bus.di_sur_valid;
    assign frame_end = wr_en && (bus.di_sur_last || (wr_cnt == ADDR_W'(MAX_LEN - 1)));

    // Read addresses run N-1 .. 0 independently of the traced state, so the
    // survivor for step t is always one cycle ahead of its use.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        rd_en   = 1'b0;
        rd_addr = len_m1;
        if (state_q == FILL) begin
            rd_en = 1'b1;
        end else if (state_q == TRACE && t_cnt != '0) begin
            rd_en   = 1'b1;
            rd_addr = t_cnt - 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_end)          state_d = FILL;
            FILL:                            state_d = TRACE;
            TRACE:   if (t_cnt == '0)        state_d = OUTPUT;
            OUTPUT:  if (out_cnt == len_m1)  state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Control datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            len_m1     <= '0;
            t_cnt      <= '0;
            out_cnt    <= '0;
            tb_state   <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.di_sur_valid && (state_q != IDLE);

            if (wr_en) begin
                if (frame_end) begin
                    wr_cnt   <= '0;
                    len_m1   <= wr_cnt;
                    tb_state <= bus.di_start_state;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            case (state_q)
                FILL: begin
                    t_cnt   <= len_m1;
                    out_cnt <= '0;
                end
                TRACE: begin
                    // S_t = {S_{t+1}[4:0], survivor bit of S_{t+1} at step t}
                    tb_state <= {tb_state[4:0], rd_data[tb_state]};
                    t_cnt    <= t_cnt - 1'b1;
                end
                OUTPUT:  out_cnt <= out_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Survivor RAM and decoded-bit buffer
    // NOTE: storage arrays are deliberately not reset; every location read is
    // written first within the same frame, and a reset port would prevent
    // mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) sur_ram[wr_cnt] <= bus.di_sur_path;
        if (rd_en) rd_data <= sur_ram[rd_addr];
        if (state_q == TRACE) bit_buf[t_cnt] <= tb_state[5];
    end

    assign bus.do_bit_valid = (state_q == OUTPUT);
    assign bus.do_bit       = bus.do_bit_valid && bit_buf[out_cnt];
    assign bus.do_bit_last  = bus.do_bit_valid && (out_cnt == len_m1);
    assign bus.do_busy      = (state_q != IDLE);
    assign bus.do_overflow  = overflow_q;

endmodule

// File: tb/tb_tbu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tbu_ctrl
//   Directed self-checking bench for tbu_ctrl. Expected decoded bits are
//   computed from the stored survivors and pushed to a queue when a frame is
//   sent; a monitor pops and compares them as the DUT emits bits.
// ---------------------------------------------------------------------------
module tb_tbu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tbu_ctrl_if bus ();

    tbu_ctrl #(.MAX_LEN(512), .ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  exp_q [$];       // {bit, last}
    logic [63:0] sv [512];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference trace-back: bit[t] = S_{t+1}[5], S_t = {S_{t+1}[4:0], sv[t][S_{t+1}]}
    task automatic push_expected(input int n, input logic [5:0] s);
        logic [5:0] st;
        logic       bits [512];
        st = s;
        for (int t = n - 1; t >= 0; t--) begin
            bits[t] = st[5];
            st      = {st[4:0], sv[t][st]};
        end
        for (int t = 0; t < n; t++) exp_q.push_back({bits[t], (t == n - 1)});
    endtask

    // Monitor: every emitted bit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.do_bit_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bit_valid", bus.do_bit_valid, 1'b0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                check("do_bit", bus.do_bit, e[1]);
                check("do_bit_last", bus.do_bit_last, e[0]);
            end
        end
    end

    // Drive one vector for one cycle; called and returning at a falling edge.
    task automatic drive_vec(input logic [63:0] p, input logic last, input logic [5:0] s);
        bus.di_sur_path    = p;
        bus.di_sur_valid   = 1'b1;
        bus.di_sur_last    = last;
        bus.di_start_state = s;
        @(negedge clk);
        bus.di_sur_valid   = 1'b0;
        bus.di_sur_last    = 1'b0;
    endtask

    // kind: 0 = zeros, 1 = ones, 2 = random. Returns mid cycle c+1.
    task automatic send_frame(input int n, input int kind, input logic [5:0] s,
                              input bit with_last, input bit push);
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       sv[i] = 64'h0;
                1:       sv[i] = 64'hFFFF_FFFF_FFFF_FFFF;
                default: sv[i] = {$urandom, $urandom};
            endcase
            drive_vec(sv[i], with_last && (i == n - 1), s);
        end
        if (push) push_expected(n, s);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((bus.do_busy || exp_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout_busy", bus.do_busy, 1'b0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.di_sur_path    = '0;
        bus.di_sur_valid   = 1'b0;
        bus.di_sur_last    = 1'b0;
        bus.di_start_state = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_do_bit_valid", bus.do_bit_valid, 1'b0);
        check("rst_do_bit_last",  bus.do_bit_last,  1'b0);
        check("rst_do_busy",      bus.do_busy,      1'b0);
        check("rst_do_overflow",  bus.do_overflow,  1'b0);
        check("rst_do_bit",       bus.do_bit,       1'b0);

        // Zero survivors, N=4, start 0; first bit at c+6
        send_frame(4, 0, 6'd0, 1'b1, 1'b1);
        check("n4_busy_at_fill", bus.do_busy, 1'b1);
        k = 1;
        while (!bus.do_bit_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("n4_first_valid_latency", 64'(k), 64'd6);
        wait_idle(40);

        // MSB-only start state, N=3: output 0,0,1; busy for 7 cycles
        @(negedge clk);
        send_frame(3, 0, 6'd32, 1'b1, 1'b1);
        k = 0;
        while (bus.do_busy && k < 50) begin
            k++;
            @(negedge clk);
        end
        check("n3_busy_cycles", 64'(k), 64'd7);
        wait_idle(40);

        // All-ones survivors, N=7, start 0: 1,0,0,0,0,0,0
        send_frame(7, 1, 6'd0, 1'b1, 1'b1);
        wait_idle(60);

        // di_sur_last without valid is ignored, then a random N=5 frame
        bus.di_sur_last = 1'b1;
        @(negedge clk);
        bus.di_sur_last = 1'b0;
        check("lone_last_ignored", bus.do_busy, 1'b0);
        send_frame(5, 2, 6'd45, 1'b1, 1'b1);
        wait_idle(60);

        // Overflow: three vectors offered during TRACE are dropped
        send_frame(8, 2, 6'd19, 1'b1, 1'b1);
        @(negedge clk);                       // mid c+2, TRACE
        for (int i = 0; i < 3; i++) begin
            bus.di_sur_path  = 64'hDEAD_BEEF_0BAD_F00D;
            bus.di_sur_valid = 1'b1;
            bus.di_sur_last  = 1'b1;
            @(negedge clk);
            check("overflow_pulse", bus.do_overflow, 1'b1);
        end
        bus.di_sur_valid = 1'b0;
        bus.di_sur_last  = 1'b0;
        @(negedge clk);
        check("overflow_cleared", bus.do_overflow, 1'b0);
        wait_idle(60);
        send_frame(6, 2, 6'd7, 1'b1, 1'b1);
        wait_idle(60);

        // Reset in the 3rd TRACE cycle of an N=8 frame: no bits follow
        send_frame(8, 2, 6'd55, 1'b1, 1'b0);
        @(negedge clk);                       // TRACE 1
        @(negedge clk);                       // TRACE 2
        @(negedge clk);                       // TRACE 3
        rst = 1'b1;
        @(negedge clk);
        check("midrst_do_bit_valid", bus.do_bit_valid, 1'b0);
        check("midrst_do_bit_last",  bus.do_bit_last,  1'b0);
        check("midrst_do_busy",      bus.do_busy,      1'b0);
        check("midrst_do_overflow",  bus.do_overflow,  1'b0);
        check("midrst_do_bit",       bus.do_bit,       1'b0);
        rst = 1'b0;
        repeat (25) @(negedge clk);           // monitor flags any stray bit
        send_frame(2, 2, 6'd33, 1'b1, 1'b1);
        wait_idle(40);

        // N=1 frame
        send_frame(1, 2, 6'd63, 1'b1, 1'b1);
        wait_idle(20);

        // Implicit last after 512 writes
        send_frame(512, 2, 6'd21, 1'b0, 1'b1);
        check("implicit_last_busy", bus.do_busy, 1'b1);
        wait_idle(1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
